reg_reduce_pipe: RTL and testbench

Parametrised N-channel, W-bit registered capture stage with a combinational cross-channel reduction on the registered outputs. It is the successor to the fixed two-flop capture plus AND/OR glue block. It adds configurable pipeline depth, valid/ready flow control and a selectable reduction mode. It sits between the input synchroniser/capture logic and downstream decision logic.

---
 rtl/reduce_pkg.sv | 49 ++++
 rtl/reduce_stage.sv | 39 +++
 rtl/reg_reduce_pipe.sv | 97 +++++++++
 tb/tb_reg_reduce_pipe.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/reduce_pkg.sv
// reduce_pkg: shared definitions for the reg_reduce_pipe capture/reduce slice.
//   MODE_*         reduction mode encodings carried alongside each beat
//   MODE_W         width of the mode field
//   MAX_N          largest channel count a single reduction column supports
//   reduce_lanes() reduces one bit position across the channels
//   dual_mode()    AND<->OR swap applied to the complement-side reduction
package reduce_pkg;

  localparam int MODE_W = 2;

  localparam logic [MODE_W-1:0] MODE_AND  = 2'b00;
  localparam logic [MODE_W-1:0] MODE_OR   = 2'b01;
  localparam logic [MODE_W-1:0] MODE_XOR  = 2'b10;
  localparam logic [MODE_W-1:0] MODE_PASS = 2'b11;

  localparam int MAX_N = 32;

  // vec[k] is channel k's bit at one bit position; only the first n
  // channels take part. Channel 0 seeds the accumulator, which is also the
  // PASS result.
  function automatic logic reduce_lanes(input logic [MAX_N-1:0] vec,
                                        input logic [MODE_W-1:0] mode,
                                        input int n);
    logic r;
    r = vec[0];
    for (int k = 1; k < MAX_N; k++) begin
      if (k < n) begin
        case (mode)
          MODE_AND: r = r & vec[k];
          MODE_OR:  r = r | vec[k];
          MODE_XOR: r = r ^ vec[k];
          default:  r = r;
        endcase
      end
    end
    return r;
  endfunction

  // The complement side uses the De Morgan dual for AND/OR so that g stays
  // the complement of f; XOR and PASS keep the same operator.
  function automatic logic [MODE_W-1:0] dual_mode(input logic [MODE_W-1:0] m);
    case (m)
      MODE_AND: return MODE_OR;
      MODE_OR:  return MODE_AND;
      default:  return m;
    endcase
  endfunction

endpackage

// File: rtl/reduce_stage.sv
// reduce_stage: one elastic pipeline register with valid/ready handshake.
//   CLK1, RST            clock, async active-high reset
//   in_valid/in_ready    upstream handshake
//   in_data              payload from upstream
//   out_valid/out_ready  downstream handshake
//   out_data             registered payload
// RST_VAL sets the payload reset image, so complement fields can come up
// as all ones.
module reduce_stage #(
  parameter int          PW      = 1,
  parameter logic [PW-1:0] RST_VAL = '0
) (
  input  logic          CLK1,
  input  logic          RST,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [PW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [PW-1:0] out_data
);

  // Load when empty or when the held beat leaves this cycle. Depends only
  // on local state and the downstream ready, never on in_valid.
  assign in_ready = !out_valid | out_ready;

  // Payload only moves with a real beat, so the last values stay visible
  // while the stage is empty.
  always_ff @(posedge CLK1 or posedge RST) begin
    if (RST) begin
      out_valid <= 1'b0;
      out_data  <= RST_VAL;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) out_data <= in_data;
    end
  end

endmodule

// File: rtl/reg_reduce_pipe.sv
// reg_reduce_pipe: N-channel, W-bit registered capture pipe with a
// cross-channel reduction on the last stage.
//   CLK1, RST            clock, async active-high reset
//   in_valid/in_ready    input beat handshake
//   D[N*W]               channel data, channel k at D[k*W +: W]
//   mode[2]              reduction mode, captured with the beat
//   out_valid/out_ready  output beat handshake
//   Q, Q_bar             last-stage data and its registered complement
//   f, g                 per-bit reductions across channels of Q / Q_bar
// Optional build macro REDUCE_XFER_CNT_EN adds xfer_cnt[15:0], a wrapping
// count of output handshakes.
module reg_reduce_pipe
  import reduce_pkg::*;
#(
  parameter int N     = 2,
  parameter int W     = 1,
  parameter int DEPTH = 1
) (
  input  logic           CLK1,
  input  logic           RST,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N*W-1:0] D,
  input  logic [1:0]     mode,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N*W-1:0] Q,
  output logic [N*W-1:0] Q_bar,
  output logic [W-1:0]   f,
  output logic [W-1:0]   g
`ifdef REDUCE_XFER_CNT_EN
  ,
  output logic [15:0]    xfer_cnt
`endif
);

  localparam int NW = N * W;
  localparam int PW = MODE_W + 2 * NW;
  // Payload is {mode, data_bar, data}; data_bar resets to ones to match Q=0.
  localparam logic [PW-1:0] RST_PLD = {{MODE_W{1'b0}}, {NW{1'b1}}, {NW{1'b0}}};

  logic [DEPTH:0]         vld_pipe;
  logic [DEPTH:0]         rdy_pipe;
  logic [DEPTH:0][PW-1:0] pld_pipe;
  logic [MODE_W-1:0]      q_mode;

  // Complement is taken at capture and carried, not rebuilt from Q.
  assign vld_pipe[0]     = in_valid;
  assign in_ready        = rdy_pipe[0];
  assign pld_pipe[0]     = {mode, ~D, D};
  assign rdy_pipe[DEPTH] = out_ready;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stg
    reduce_stage #(.PW(PW), .RST_VAL(RST_PLD)) u_stg (
      .CLK1      (CLK1),
      .RST       (RST),
      .in_valid  (vld_pipe[gi]),
      .in_ready  (rdy_pipe[gi]),
      .in_data   (pld_pipe[gi]),
      .out_valid (vld_pipe[gi+1]),
      .out_ready (rdy_pipe[gi+1]),
      .out_data  (pld_pipe[gi+1])
    );
  end

  assign out_valid = vld_pipe[DEPTH];
  assign Q         = pld_pipe[DEPTH][NW-1:0];
  assign Q_bar     = pld_pipe[DEPTH][2*NW-1:NW];
  assign q_mode    = pld_pipe[DEPTH][PW-1:2*NW];

  // Gather each bit position into a channel column, zero-padded to MAX_N,
  // and reduce it. Padding never takes part since reduce_lanes stops at N.
  logic [W-1:0][MAX_N-1:0] q_col;
  logic [W-1:0][MAX_N-1:0] qb_col;

  for (genvar b = 0; b < W; b++) begin : g_bit
    for (genvar k = 0; k < MAX_N; k++) begin : g_ch
      if (k < N) begin : g_use
        assign q_col[b][k]  = Q[k*W+b];
        assign qb_col[b][k] = Q_bar[k*W+b];
      end else begin : g_pad
        assign q_col[b][k]  = 1'b0;
        assign qb_col[b][k] = 1'b0;
      end
    end
    assign f[b] = reduce_lanes(q_col[b], q_mode, N);
    assign g[b] = reduce_lanes(qb_col[b], dual_mode(q_mode), N);
  end

`ifdef REDUCE_XFER_CNT_EN
  always_ff @(posedge CLK1 or posedge RST) begin
    if (RST) xfer_cnt <= '0;
    else if (out_valid & out_ready) xfer_cnt <= xfer_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_reg_reduce_pipe.sv
// tb_reg_reduce_pipe: self-checking bench for reg_reduce_pipe.
// dut_a: N=4, W=4, DEPTH=3 with a queue scoreboard; dut_b: N=2, W=1, DEPTH=1.
module tb_reg_reduce_pipe;

  logic CLK1 = 1'b0;
  logic RST;
  always #5 CLK1 = ~CLK1;

  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [15:0] a_D, a_Q, a_Qb;
  logic [1:0]  a_mode;
  logic [3:0]  a_f, a_g;
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [1:0]  b_D, b_Q, b_Qb, b_mode;
  logic        b_f, b_g;
`ifdef REDUCE_XFER_CNT_EN
  logic [15:0] a_cnt, b_cnt;
`endif

  reg_reduce_pipe #(.N(4), .W(4), .DEPTH(3)) dut_a (
    .CLK1(CLK1), .RST(RST), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .D(a_D), .mode(a_mode), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .Q(a_Q), .Q_bar(a_Qb), .f(a_f), .g(a_g)
`ifdef REDUCE_XFER_CNT_EN
    , .xfer_cnt(a_cnt)
`endif
  );

  reg_reduce_pipe #(.N(2), .W(1), .DEPTH(1)) dut_b (
    .CLK1(CLK1), .RST(RST), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .D(b_D), .mode(b_mode), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .Q(b_Q), .Q_bar(b_Qb), .f(b_f), .g(b_g)
`ifdef REDUCE_XFER_CNT_EN
    , .xfer_cnt(b_cnt)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;
  int n_xfer = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference: count ones per bit position across the 4 channels.
  task automatic model(input logic [15:0] d, input logic [1:0] m,
                       output logic [3:0] ef, output logic [3:0] eg);
    int cnt;
    for (int b = 0; b < 4; b++) begin
      cnt = 0;
      for (int k = 0; k < 4; k++) cnt += int'(d[k*4+b]);
      case (m)
        2'd0: begin ef[b] = (cnt == 4); eg[b] = (cnt != 4); end
        2'd1: begin ef[b] = (cnt > 0);  eg[b] = (cnt == 0); end
        2'd2: begin ef[b] = (cnt % 2 == 1); eg[b] = ((4 - cnt) % 2 == 1); end
        default: begin ef[b] = d[b]; eg[b] = !d[b]; end
      endcase
    end
  endtask

  typedef struct { logic [15:0] d; logic [1:0] m; } beat_t;
  beat_t sb[$];

  always @(negedge CLK1) begin
    beat_t e;
    logic [3:0] ef, eg;
    logic [15:0] eb;
    if (!RST) begin
      if (a_out_valid && a_out_ready) begin
        if (sb.size() == 0) chk("sb_underflow", 64'd1, 64'd0);
        else begin
          e = sb.pop_front();
          model(e.d, e.m, ef, eg);
          eb = ~e.d;
          chk("q", a_Q, e.d);
          chk("qbar", a_Qb, eb);
          chk("f", a_f, ef);
          chk("g", a_g, eg);
          n_xfer++;
        end
      end
      if (a_in_valid && a_in_ready) sb.push_back('{a_D, a_mode});
    end
  end

  task automatic wait_ov(input string tag);
    int n = 0;
    while (!a_out_valid && n < 50) begin @(posedge CLK1); #1; n++; end
    chk(tag, a_out_valid, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    int lat, acc, guard, x0;
    logic [15:0] tmp;
`ifdef REDUCE_XFER_CNT_EN
    logic [15:0] cnt0;
`endif
    RST = 1'b1;
    a_in_valid = 0; a_out_ready = 0; a_D = '0; a_mode = '0;
    b_in_valid = 0; b_out_ready = 1; b_D = '0; b_mode = '0;
    repeat (2) @(posedge CLK1);
    #1;
    chk("rst_ov", a_out_valid, 0);
    chk("rst_q", a_Q, 16'h0);
    chk("rst_qb", a_Qb, 16'hFFFF);
    chk("rst_f", a_f, 4'h0);
    chk("rst_g", a_g, 4'hF);
    chk("rst_ir", a_in_ready, 1);
    RST = 1'b0;

    // Small instance, AND mode.
    @(posedge CLK1); #1;
    b_in_valid = 1; b_D = 2'b11;
    @(posedge CLK1); #1;
    chk("b_ov", b_out_valid, 1);
    chk("b_f1", b_f, 1);
    chk("b_g1", b_g, 0);
    b_D = 2'b01;
    @(posedge CLK1); #1;
    chk("b_f2", b_f, 0);
    chk("b_g2", b_g, 1);
    b_in_valid = 0;

    // XOR mode, latency = DEPTH.
    a_out_ready = 1; a_mode = 2'b10; a_D = 16'hF350; a_in_valid = 1;
    @(posedge CLK1); #1;
    a_in_valid = 0;
    lat = 1;
    while (!a_out_valid && lat < 20) begin @(posedge CLK1); #1; lat++; end
    chk("xor_lat", lat, 3);
    chk("xor_f", a_f, 4'h9);
    chk("xor_g", a_g, 4'h9);

    // PASS then OR: mode travels with its own beat.
    tmp = 16'($urandom);
    a_mode = 2'b11; a_D = {tmp[15:4], 4'hA}; a_in_valid = 1;
    @(posedge CLK1); #1;
    a_mode = 2'b01; a_D = 16'($urandom);
    @(posedge CLK1); #1;
    a_in_valid = 0;
    wait_ov("pass_ov");
    chk("pass_f", a_f, 4'hA);
    chk("pass_g", a_g, 4'h5);
    repeat (5) @(posedge CLK1);
    #1;

    // Backpressure: three beats fill the pipe, the fourth waits.
    a_out_ready = 0; a_mode = 2'b00; a_in_valid = 1;
    for (int k = 1; k <= 3; k++) begin
      a_D = 16'(k);
      @(negedge CLK1);
      chk("bp_rdy", a_in_ready, 1);
      @(posedge CLK1); #1;
    end
    a_D = 16'd4;
    @(negedge CLK1);
    chk("bp_full", a_in_ready, 0);
    repeat (3) @(posedge CLK1);
    #1;
    chk("bp_hold", a_in_ready, 0);
    a_out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK1);
      chk("bp_nogap", a_out_valid, 1);
      if (i == 0) chk("bp_shift", a_in_ready, 1);
      @(posedge CLK1); #1;
      a_in_valid = 0;
    end
    repeat (5) @(posedge CLK1);
    #1;
    chk("bp_empty", sb.size(), 0);

    // Random streaming against the scoreboard.
    x0 = n_xfer;
`ifdef REDUCE_XFER_CNT_EN
    cnt0 = a_cnt;
`endif
    acc = 0; guard = 0;
    while (acc < 100 && guard < 5000) begin
      a_in_valid  = 1'($urandom);
      a_mode      = 2'($urandom);
      a_D         = 16'($urandom);
      a_out_ready = ($urandom % 4) != 0;
      @(negedge CLK1);
      if (a_in_valid && a_in_ready) acc++;
      @(posedge CLK1); #1;
      guard++;
    end
    a_in_valid = 0; a_out_ready = 1;
    guard = 0;
    while (sb.size() != 0 && guard < 100) begin @(posedge CLK1); #1; guard++; end
    chk("stream_drain", sb.size(), 0);
    chk("stream_xfers", n_xfer - x0, 100);
`ifdef REDUCE_XFER_CNT_EN
    chk("stream_cnt", a_cnt - cnt0, 16'd100);
`endif

    // Reset with a full pipe, asserted mid-cycle.
    a_out_ready = 0; a_in_valid = 1;
    repeat (3) begin
      a_D = 16'($urandom); a_mode = 2'($urandom);
      @(posedge CLK1); #1;
    end
    a_in_valid = 0;
    @(posedge CLK1); #3;
    chk("pre_rst_ov", a_out_valid, 1);
    RST = 1'b1;
    #1;
    sb.delete();
    chk("mrst_ov", a_out_valid, 0);
    chk("mrst_q", a_Q, 16'h0);
    chk("mrst_qb", a_Qb, 16'hFFFF);
    chk("mrst_f", a_f, 4'h0);
    chk("mrst_g", a_g, 4'hF);
    @(posedge CLK1); #1;
    RST = 1'b0;
    chk("mrst_ir", a_in_ready, 1);
`ifdef REDUCE_XFER_CNT_EN
    chk("mrst_cnt", a_cnt, 16'h0);
`endif
    a_out_ready = 1; a_in_valid = 1;
    a_D = 16'($urandom); a_mode = 2'($urandom);
    @(posedge CLK1); #1;
    a_in_valid = 0;
    wait_ov("post_rst_ov");
    repeat (3) @(posedge CLK1);
    #1;
    chk("post_rst_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
